// File: rtl/candy_vend_ctrl.sv
// Candy vending transaction controller: two-slot coin arbitration, vend handshake, 5c change payout.
// Optional vend watchdog (fault + refund + lock) is enabled by defining CANDY_VEND_WDOG_EN.
module candy_vend_ctrl #(
    parameter int PRICE            = 15,
    parameter int TIMEOUT_CYCLES   = 1000,
    parameter int VEND_WDOG_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin5_req,
    input  logic       coin10_req,
    input  logic       cancel,
    input  logic       vend_done,
    output logic       coin5_ack,
    output logic       coin10_ack,
    output logic       vend_o,
    output logic       change_o,
    output logic [7:0] credit_o,
    output logic [2:0] state_o,
    output logic       fault_o
);

    typedef enum logic [2:0] {
        ACCEPT = 3'b000,
        VEND   = 3'b001,
        PAYOUT = 3'b010,
        LOCKED = 3'b011
    } state_t;

`ifdef CANDY_VEND_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int WW = $clog2(VEND_WDOG_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] W_LAST  = WW'(VEND_WDOG_CYCLES - 1);
    localparam logic [7:0]    PRICE_C = 8'(PRICE);

    state_t        state, state_nxt;
    logic [7:0]    credit_nxt;
    logic          ack5_nxt, ack10_nxt, vend_nxt, change_nxt, fault_nxt;
    logic          last5, last5_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic          elig5, elig10, grant5, grant10;
    logic [7:0]    credit_add, credit_sub;

    // A held request is not eligible while its own ack is high, so one coin counts once.
    assign elig5      = coin5_req && !coin5_ack;
    assign elig10     = coin10_req && !coin10_ack;
    assign grant5     = elig5 && (!elig10 || !last5);
    assign grant10    = elig10 && !grant5;
    assign credit_add = credit_o + (grant5 ? 8'd5 : 8'd10);
    assign credit_sub = credit_o - PRICE_C;
    assign state_o    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ACCEPT;
            credit_o   <= '0;
            coin5_ack  <= 1'b0;
            coin10_ack <= 1'b0;
            vend_o     <= 1'b0;
            change_o   <= 1'b0;
            fault_o    <= 1'b0;
            last5      <= 1'b0;
            tcnt       <= '0;
            wcnt       <= '0;
        end else begin
            state      <= state_nxt;
            credit_o   <= credit_nxt;
            coin5_ack  <= ack5_nxt;
            coin10_ack <= ack10_nxt;
            vend_o     <= vend_nxt;
            change_o   <= change_nxt;
            fault_o    <= fault_nxt;
            last5      <= last5_nxt;
            tcnt       <= tcnt_nxt;
            wcnt       <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit_o;
        ack5_nxt   = 1'b0;
        ack10_nxt  = 1'b0;
        vend_nxt   = 1'b0;
        change_nxt = 1'b0;
        fault_nxt  = fault_o;
        last5_nxt  = last5;
        tcnt_nxt   = tcnt;
        wcnt_nxt   = '0;
        case (state)
            ACCEPT: begin
                if (cancel && credit_o != 8'd0) begin
                    state_nxt  = PAYOUT;
                    change_nxt = 1'b1;
                    tcnt_nxt   = '0;
                end else if (grant5 || grant10) begin
                    credit_nxt = credit_add;
                    ack5_nxt   = grant5;
                    ack10_nxt  = grant10;
                    last5_nxt  = grant5;
                    tcnt_nxt   = '0;
                    if (credit_add >= PRICE_C) begin
                        state_nxt = VEND;
                        vend_nxt  = 1'b1;
                    end
                end else if (credit_o != 8'd0) begin
                    if (tcnt == T_LAST) begin
                        state_nxt  = PAYOUT;
                        change_nxt = 1'b1;
                        tcnt_nxt   = '0;
                    end else begin
                        tcnt_nxt = tcnt + 1'b1;
                    end
                end
            end
            VEND: begin
                vend_nxt = 1'b1;
                if (vend_done) begin
                    vend_nxt   = 1'b0;
                    credit_nxt = credit_sub;
                    if (credit_sub != 8'd0) begin
                        state_nxt  = PAYOUT;
                        change_nxt = 1'b1;
                    end else begin
                        state_nxt = ACCEPT;
                    end
                end else if (WDOG_EN && wcnt == W_LAST) begin
                    // Motor never reported: refund everything, then lock.
                    vend_nxt   = 1'b0;
                    fault_nxt  = 1'b1;
                    state_nxt  = PAYOUT;
                    change_nxt = 1'b1;
                end else if (WDOG_EN) begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            PAYOUT: begin
                // Pulse high one cycle, low the next; credit drops as each pulse ends.
                if (change_o) begin
                    credit_nxt = credit_o - 8'd5;
                end else if (credit_o == 8'd0) begin
                    state_nxt = fault_o ? LOCKED : ACCEPT;
                end else begin
                    change_nxt = 1'b1;
                end
            end
            LOCKED: begin
                state_nxt = LOCKED;
            end
            default: begin
                state_nxt = ACCEPT;
            end
        endcase
    end

endmodule

// File: tb/tb_candy_vend_ctrl.sv
// Self-checking bench for candy_vend_ctrl: vector table, hand sequences, randomized run vs. reference model.
// Watchdog sequence is included when CANDY_VEND_WDOG_EN is defined.
module tb_candy_vend_ctrl;

    localparam int PRICE = 15;
    localparam int TMO   = 40;
    localparam int WDOG  = 60;
`ifdef CANDY_VEND_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       coin5_req = 1'b0, coin10_req = 1'b0, cancel = 1'b0, vend_done = 1'b0;
    logic       coin5_ack, coin10_ack, vend_o, change_o, fault_o;
    logic [7:0] credit_o;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    candy_vend_ctrl #(
        .PRICE(PRICE), .TIMEOUT_CYCLES(TMO), .VEND_WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .reset(reset),
        .coin5_req(coin5_req), .coin10_req(coin10_req),
        .cancel(cancel), .vend_done(vend_done),
        .coin5_ack(coin5_ack), .coin10_ack(coin10_ack),
        .vend_o(vend_o), .change_o(change_o),
        .credit_o(credit_o), .state_o(state_o), .fault_o(fault_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit c5, c10, can, vd;
        bit a5, a10, vend, chg;
        int cr, st;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t v(bit c5, bit c10, bit can, bit vd,
                               bit a5, bit a10, bit vend, bit chg, int cr, int st);
        vec_t r;
        r.c5 = c5; r.c10 = c10; r.can = can; r.vd = vd;
        r.a5 = a5; r.a10 = a10; r.vend = vend; r.chg = chg; r.cr = cr; r.st = st;
        return r;
    endfunction

    task automatic check_out(input string name, input bit a5, input bit a10, input bit vend,
                             input bit chg, input int cr, input int st, input bit flt);
        n_tests++;
        if (coin5_ack !== a5 || coin10_ack !== a10 || vend_o !== vend || change_o !== chg ||
            credit_o !== 8'(cr) || state_o !== 3'(st) || fault_o !== flt) begin
            n_fail++;
            $display("FAIL %s: got ack5=%b ack10=%b vend=%b chg=%b credit=%0d state=%0d fault=%b, expected ack5=%b ack10=%b vend=%b chg=%b credit=%0d state=%0d fault=%b",
                     name, coin5_ack, coin10_ack, vend_o, change_o, credit_o, state_o, fault_o,
                     a5, a10, vend, chg, cr, st, flt);
        end
    endtask

    task automatic step(input bit c5, input bit c10, input bit can, input bit vd);
        coin5_req = c5; coin10_req = c10; cancel = can; vend_done = vd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    // Reference model: state as 0=accept 1=vend 2=payout 3=locked; payout tracked as cycles remaining.
    int m_st, m_credit, m_pay, m_idle, m_vcnt;
    bit m_ack5, m_ack10, m_last5, m_fault;

    function automatic void model_reset();
        m_st = 0; m_credit = 0; m_pay = 0; m_idle = 0; m_vcnt = 0;
        m_ack5 = 0; m_ack10 = 0; m_last5 = 0; m_fault = 0;
    endfunction

    function automatic void model_step(bit r5, bit r10, bit can, bit vd);
        bit e5, e10, g5;
        e5 = r5 && !m_ack5;
        e10 = r10 && !m_ack10;
        m_ack5 = 0;
        m_ack10 = 0;
        case (m_st)
            0: begin
                if (can && m_credit > 0) begin
                    m_pay = 2 * m_credit / 5; m_st = 2; m_idle = 0;
                end else if (e5 || e10) begin
                    g5 = e5 && !(e10 && m_last5);
                    m_credit += g5 ? 5 : 10;
                    m_ack5 = g5; m_ack10 = !g5; m_last5 = g5; m_idle = 0;
                    if (m_credit >= PRICE) begin m_st = 1; m_vcnt = 0; end
                end else if (m_credit > 0) begin
                    m_idle++;
                    if (m_idle == TMO) begin m_pay = 2 * m_credit / 5; m_st = 2; m_idle = 0; end
                end
            end
            1: begin
                if (vd) begin
                    m_credit -= PRICE;
                    if (m_credit > 0) begin m_pay = 2 * m_credit / 5; m_st = 2; end
                    else m_st = 0;
                end else if (WDOG_ON) begin
                    m_vcnt++;
                    if (m_vcnt == WDOG) begin m_fault = 1; m_pay = 2 * m_credit / 5; m_st = 2; end
                end
            end
            2: begin
                m_pay--;
                if (m_pay == 0) begin m_credit = 0; m_st = m_fault ? 3 : 0; end
            end
            default: ;
        endcase
    endfunction

    task automatic check_model(input string name);
        int cr;
        cr = (m_st == 2) ? 5 * (m_pay / 2) : m_credit;
        check_out(name, m_ack5, m_ack10, m_st == 1, (m_st == 2) && (m_pay % 2 == 0), cr, m_st, m_fault);
    endtask

    initial begin
        int pulses;
        bit r5, r10, can, vd;
        int rate;

        vt.push_back(v(1,0,0,0, 1,0,0,0,  5,0));
        vt.push_back(v(0,0,0,0, 0,0,0,0,  5,0));
        vt.push_back(v(1,0,0,0, 1,0,0,0, 10,0));
        vt.push_back(v(0,0,0,0, 0,0,0,0, 10,0));
        vt.push_back(v(1,0,0,0, 1,0,1,0, 15,1));
        vt.push_back(v(0,0,0,0, 0,0,1,0, 15,1));
        vt.push_back(v(0,0,0,1, 0,0,0,0,  0,0));
        vt.push_back(v(0,0,1,0, 0,0,0,0,  0,0));
        vt.push_back(v(0,1,0,0, 0,1,0,0, 10,0));
        vt.push_back(v(0,0,0,1, 0,0,0,0, 10,0));
        vt.push_back(v(0,1,0,0, 0,1,1,0, 20,1));
        vt.push_back(v(0,0,0,1, 0,0,0,1,  5,2));
        vt.push_back(v(0,0,0,0, 0,0,0,0,  0,2));
        vt.push_back(v(0,0,0,0, 0,0,0,0,  0,0));
        vt.push_back(v(1,1,0,0, 1,0,0,0,  5,0));
        vt.push_back(v(1,1,0,0, 0,1,1,0, 15,1));
        vt.push_back(v(0,0,0,1, 0,0,0,0,  0,0));
        vt.push_back(v(1,0,0,0, 1,0,0,0,  5,0));
        vt.push_back(v(0,0,0,0, 0,0,0,0,  5,0));
        vt.push_back(v(1,1,0,0, 0,1,1,0, 15,1));
        vt.push_back(v(1,0,0,0, 0,0,1,0, 15,1));
        vt.push_back(v(1,0,0,1, 0,0,0,0,  0,0));
        vt.push_back(v(1,0,0,0, 1,0,0,0,  5,0));
        vt.push_back(v(0,0,0,0, 0,0,0,0,  5,0));
        vt.push_back(v(0,1,1,0, 0,0,0,1,  5,2));
        vt.push_back(v(0,1,0,0, 0,0,0,0,  0,2));
        vt.push_back(v(0,1,0,0, 0,0,0,0,  0,0));
        vt.push_back(v(0,1,0,0, 0,1,0,0, 10,0));
        vt.push_back(v(0,0,0,0, 0,0,0,0, 10,0));

        do_reset();
        check_out("reset", 0, 0, 0, 0, 0, 0, 0);

        foreach (vt[i]) begin
            step(vt[i].c5, vt[i].c10, vt[i].can, vt[i].vd);
            check_out($sformatf("vec%0d", i), vt[i].a5, vt[i].a10, vt[i].vend, vt[i].chg,
                      vt[i].cr, vt[i].st, 0);
        end

        // Credit 10 has sat idle one cycle; idle out the rest of the timeout window.
        for (int i = 0; i < TMO - 2; i++) step(0, 0, 0, 0);
        check_out("tmo_before", 0, 0, 0, 0, 10, 0, 0);
        step(0, 0, 0, 0);
        check_out("tmo_pulse1", 0, 0, 0, 1, 10, 2, 0);
        step(0, 0, 0, 0);
        check_out("tmo_low1", 0, 0, 0, 0, 5, 2, 0);
        step(0, 0, 0, 0);
        check_out("tmo_pulse2", 0, 0, 0, 1, 5, 2, 0);
        step(0, 0, 0, 0);
        check_out("tmo_low2", 0, 0, 0, 0, 0, 2, 0);
        step(0, 0, 0, 0);
        check_out("tmo_accept", 0, 0, 0, 0, 0, 0, 0);

        if (WDOG_ON) begin
            do_reset();
            step(1, 0, 0, 0); step(0, 0, 0, 0);
            step(1, 0, 0, 0); step(0, 0, 0, 0);
            step(1, 0, 0, 0);
            check_out("wd_vend", 1, 0, 1, 0, 15, 1, 0);
            for (int i = 0; i < WDOG - 1; i++) step(0, 0, 0, 0);
            check_out("wd_wait", 0, 0, 1, 0, 15, 1, 0);
            step(0, 0, 0, 0);
            check_out("wd_trip", 0, 0, 0, 1, 15, 2, 1);
            pulses = 1;
            for (int i = 0; i < 5; i++) begin
                step(0, 0, 0, 0);
                pulses += int'(change_o);
            end
            n_tests++;
            if (pulses != 3) begin
                n_fail++;
                $display("FAIL wd_pulses: got %0d change pulses, expected 3", pulses);
            end
            step(1, 0, 0, 0);
            check_out("wd_locked", 0, 0, 0, 0, 0, 3, 1);
            step(1, 0, 0, 0);
            check_out("wd_locked_nogrant", 0, 0, 0, 0, 0, 3, 1);
            do_reset();
            check_out("wd_reset", 0, 0, 0, 0, 0, 0, 0);
        end

        do_reset();
        model_reset();
        check_model("rnd_reset");
        r5 = 0; r10 = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rate = ((cyc / 500) % 2 == 1) ? 60 : 3;
            if (r5 && m_ack5) r5 = ($urandom_range(0, 7) == 0);
            else if (!r5 && $urandom_range(0, rate) == 0) r5 = 1;
            if (r10 && m_ack10) r10 = ($urandom_range(0, 7) == 0);
            else if (!r10 && $urandom_range(0, rate) == 0) r10 = 1;
            can = ($urandom_range(0, 39) == 0);
            vd  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b1;
                step(r5, r10, can, vd);
                reset = 1'b0;
                model_reset();
                check_model("rnd_midreset");
            end else begin
                model_step(r5, r10, can, vd);
                step(r5, r10, can, vd);
                check_model($sformatf("rnd%0d", cyc));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
